load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: WORD_WIDTH, 32, data/address word width (from riscv_defines).
REQ-002 Parameter: ADDR_WIDTH, 5, register-file index width (from riscv_defines).
REQ-003 One clock; reset is asynchronous and active-low. Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- lsu_req_i  in  1  memory op request from execute
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_size_i  in  2  00 byte, 01 half, 10/11 word
- lsu_sign_ext_i  in  1  load sign-extend enable
- lsu_addr_i  in  WORD_WIDTH  effective byte address
- lsu_wdata_i  in  WORD_WIDTH  store data (register-bank read port 2)
- lsu_rd_addr_i  in  ADDR_WIDTH  load destination register
- lsu_ready_o  out  1  unit can accept a request
- misaligned_o  out  1  misaligned-access pulse
- data_req_o  out  1  bus request
- data_gnt_i  in  1  bus grant
- data_rvalid_i  in  1  bus response valid
- data_addr_o  out  WORD_WIDTH  word-aligned bus address
- data_we_o  out  1  bus write enable
- data_be_o  out  4  byte enables
- data_wdata_o  out  WORD_WIDTH  bus write data
- data_rdata_i  in  WORD_WIDTH  bus read data
- wb_en_o  out  1  register-bank write enable
- wb_addr_o  out  ADDR_WIDTH  register-bank write address
- wb_data_o  out  WORD_WIDTH  register-bank write data

Function
REQ-004 FSM states: IDLE, REQ, WAIT_RVALID; lsu_ready_o = 1 only in IDLE.
REQ-005 Accept when lsu_req_i && lsu_ready_o; all request fields captured into registers that cycle.
REQ-006 Misaligned: half with addr[0]=1, or word with addr[1:0]!=0 -> no bus request; misaligned_o = 1 for exactly the cycle after acceptance; FSM stays IDLE.
REQ-007 Aligned accept -> REQ next cycle; data_req_o = 1 in REQ; data_addr_o/we/be/wdata held stable until data_gnt_i.
REQ-008 data_gnt_i in REQ -> WAIT_RVALID next cycle; data_req_o drops the same edge.
REQ-009 data_rvalid_i in WAIT_RVALID -> IDLE next cycle; data_rvalid_i in any other state is ignored.
REQ-010 data_addr_o = {addr[31:2], 2'b00}.
REQ-011 data_be_o: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-012 data_wdata_o: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-013 Load result: data_rdata_i >> (8*addr[1:0]), low 8/16/32 bits, sign- or zero-extended per lsu_sign_ext_i.
REQ-014 Load rvalid -> wb_en_o = 1 for exactly the next cycle with wb_addr_o = rd, wb_data_o = result; no write-back when rd = 0 or on stores.
REQ-015 Minimum load latency: accept at T, req T+1, gnt T+1, rvalid T+2, wb_en_o T+3; lsu_ready_o = 1 again at T+3, so a new request may be accepted concurrently with wb_en_o.
REQ-016 Bus contract: data_rvalid_i never earlier than the cycle after data_gnt_i; one outstanding transaction maximum.

Reset
REQ-017 rst_n low forces immediately: state IDLE, lsu_ready_o=1, data_req_o=0, data_we_o=0, data_be_o=0, data_addr_o=0, data_wdata_o=0, wb_en_o=0, wb_addr_o=0, wb_data_o=0, misaligned_o=0.
REQ-018 Reset mid-transaction abandons it; a later data_rvalid_i for it produces no write-back.

Verification
REQ-019 Load byte signed addr 0x1003, rd=5, rdata 0x80FF_FFFF, gnt/rvalid immediate -> be 0001<<3=1000, data_addr 0x1000, wb_en_o at T+3, wb_data 0xFFFF_FF80, wb_addr 5.
REQ-020 Store half addr 0x2002, wdata 0x1234_ABCD, gnt delayed 3 cycles -> data_req_o held 4 cycles, be 1100, wdata 0xABCD_ABCD, we=1, no wb_en_o.
REQ-021 Load word addr 0x3001 -> misaligned_o single pulse at T+1, data_req_o never asserted, lsu_ready_o stays 1.
REQ-022 Load half unsigned addr 0x4002, rd=0, rdata 0xBEEF_0000 -> full bus transaction, wb_en_o stays 0.
REQ-023 Back-to-back loads: second lsu_req_i accepted in wb cycle of first -> both write-backs correct, one outstanding request at a time.
REQ-024 rst_n asserted in WAIT_RVALID, rvalid arrives post-reset -> outputs at reset values, no write-back.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns execute-stage memory requests into single-outstanding
// bus transactions and formats load data for register write-back.
module load_store_unit #(
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  lsu_req_i,
   input  logic                  lsu_we_i,
   input  logic [1:0]            lsu_size_i,
   input  logic                  lsu_sign_ext_i,
   input  logic [WORD_WIDTH-1:0] lsu_addr_i,
   input  logic [WORD_WIDTH-1:0] lsu_wdata_i,
   input  logic [ADDR_WIDTH-1:0] lsu_rd_addr_i,
   output logic                  lsu_ready_o,
   output logic                  misaligned_o,
   output logic                  data_req_o,
   input  logic                  data_gnt_i,
   input  logic                  data_rvalid_i,
   output logic [WORD_WIDTH-1:0] data_addr_o,
   output logic                  data_we_o,
   output logic [3:0]            data_be_o,
   output logic [WORD_WIDTH-1:0] data_wdata_o,
   input  logic [WORD_WIDTH-1:0] data_rdata_i,
   output logic                  wb_en_o,
   output logic [ADDR_WIDTH-1:0] wb_addr_o,
   output logic [WORD_WIDTH-1:0] wb_data_o
);

   localparam int unsigned BE_WIDTH = 4;
   localparam logic [1:0]  SIZE_BYTE = 2'b00;
   localparam logic [1:0]  SIZE_HALF = 2'b01;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RVALID} state_t;

   state_t                state_q, state_d;

   // captured request fields needed after acceptance
   logic                  we_q, we_d;
   logic [1:0]            size_q, size_d;
   logic                  sext_q, sext_d;
   logic [1:0]            off_q, off_d;
   logic [ADDR_WIDTH-1:0] rd_q, rd_d;

   logic                  ready_d;
   logic                  mis_d;
   logic                  req_d;
   logic [WORD_WIDTH-1:0] addr_d;
   logic                  bus_we_d;
   logic [BE_WIDTH-1:0]   be_d;
   logic [WORD_WIDTH-1:0] wdata_d;
   logic                  wb_en_d;
   logic [ADDR_WIDTH-1:0] wb_addr_d;
   logic [WORD_WIDTH-1:0] wb_data_d;

   logic                  misaligned_c;
   logic [BE_WIDTH-1:0]   be_c;
   logic [WORD_WIDTH-1:0] wdata_c;
   logic [WORD_WIDTH-1:0] shifted_c;
   logic [WORD_WIDTH-1:0] load_c;

   // request decode: alignment, lane enables and replicated store data
   always_comb begin
      misaligned_c = 1'b0;
      be_c         = 4'b1111;
      wdata_c      = lsu_wdata_i;
      unique case (lsu_size_i)
         SIZE_BYTE: begin
            be_c    = 4'b0001 << lsu_addr_i[1:0];
            wdata_c = {4{lsu_wdata_i[7:0]}};
         end
         SIZE_HALF: begin
            misaligned_c = lsu_addr_i[0];
            be_c         = 4'b0011 << {lsu_addr_i[1], 1'b0};
            wdata_c      = {2{lsu_wdata_i[15:0]}};
         end
         default: begin
            misaligned_c = (lsu_addr_i[1:0] != 2'b00);
         end
      endcase
   end

   // load formatting: align the addressed lane to bit 0, then extend
   always_comb begin
      shifted_c = data_rdata_i >> {off_q, 3'b000};
      unique case (size_q)
         SIZE_BYTE: load_c = {{(WORD_WIDTH-8){sext_q & shifted_c[7]}}, shifted_c[7:0]};
         SIZE_HALF: load_c = {{(WORD_WIDTH-16){sext_q & shifted_c[15]}}, shifted_c[15:0]};
         default:   load_c = shifted_c;
      endcase
   end

   // next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      size_d    = size_q;
      sext_d    = sext_q;
      off_d     = off_q;
      rd_d      = rd_q;
      mis_d     = 1'b0;
      req_d     = data_req_o;
      addr_d    = data_addr_o;
      bus_we_d  = data_we_o;
      be_d      = data_be_o;
      wdata_d   = data_wdata_o;
      wb_en_d   = 1'b0;
      wb_addr_d = wb_addr_o;
      wb_data_d = wb_data_o;

      unique case (state_q)
         IDLE: begin
            if (lsu_req_i && lsu_ready_o) begin
               we_d   = lsu_we_i;
               size_d = lsu_size_i;
               sext_d = lsu_sign_ext_i;
               off_d  = lsu_addr_i[1:0];
               rd_d   = lsu_rd_addr_i;
               if (misaligned_c) begin
                  mis_d = 1'b1;
               end else begin
                  state_d  = REQ;
                  req_d    = 1'b1;
                  addr_d   = {lsu_addr_i[WORD_WIDTH-1:2], 2'b00};
                  bus_we_d = lsu_we_i;
                  be_d     = be_c;
                  wdata_d  = wdata_c;
               end
            end
         end
         REQ: begin
            if (data_gnt_i) begin
               state_d = WAIT_RVALID;
               req_d   = 1'b0;
            end
         end
         WAIT_RVALID: begin
            if (data_rvalid_i) begin
               state_d = IDLE;
               if (!we_q) begin
                  wb_en_d   = (rd_q != '0);
                  wb_addr_d = rd_q;
                  wb_data_d = load_c;
               end
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase

      ready_d = (state_d == IDLE);
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         size_q       <= 2'b00;
         sext_q       <= 1'b0;
         off_q        <= 2'b00;
         rd_q         <= '0;
         lsu_ready_o  <= 1'b1;
         misaligned_o <= 1'b0;
         data_req_o   <= 1'b0;
         data_addr_o  <= '0;
         data_we_o    <= 1'b0;
         data_be_o    <= '0;
         data_wdata_o <= '0;
         wb_en_o      <= 1'b0;
         wb_addr_o    <= '0;
         wb_data_o    <= '0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         size_q       <= size_d;
         sext_q       <= sext_d;
         off_q        <= off_d;
         rd_q         <= rd_d;
         lsu_ready_o  <= ready_d;
         misaligned_o <= mis_d;
         data_req_o   <= req_d;
         data_addr_o  <= addr_d;
         data_we_o    <= bus_we_d;
         data_be_o    <= be_d;
         data_wdata_o <= wdata_d;
         wb_en_o      <= wb_en_d;
         wb_addr_o    <= wb_addr_d;
         wb_data_o    <= wb_data_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a transaction-level model.
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        lsu_req_i;
   logic        lsu_we_i;
   logic [1:0]  lsu_size_i;
   logic        lsu_sign_ext_i;
   logic [31:0] lsu_addr_i;
   logic [31:0] lsu_wdata_i;
   logic [4:0]  lsu_rd_addr_i;
   logic        lsu_ready_o;
   logic        misaligned_o;
   logic        data_req_o;
   logic        data_gnt_i;
   logic        data_rvalid_i;
   logic [31:0] data_addr_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_wdata_o;
   logic [31:0] data_rdata_i;
   logic        wb_en_o;
   logic [4:0]  wb_addr_o;
   logic [31:0] wb_data_o;

   load_store_unit #(.WORD_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
      .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_addr_i(lsu_addr_i),
      .lsu_wdata_i(lsu_wdata_i), .lsu_rd_addr_i(lsu_rd_addr_i),
      .lsu_ready_o(lsu_ready_o), .misaligned_o(misaligned_o),
      .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
      .data_rvalid_i(data_rvalid_i), .data_addr_o(data_addr_o),
      .data_we_o(data_we_o), .data_be_o(data_be_o),
      .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
      .wb_en_o(wb_en_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // model: 0 = free, 1 = bus request outstanding, 2 = awaiting response
   int          m_phase;
   bit          t_load, t_sext;
   int          t_off, t_n;
   logic [4:0]  t_rd;
   logic        e_ready, e_mis, e_req, e_we, e_wb_en;
   logic [31:0] e_addr, e_wdata, e_wb_data;
   logic [3:0]  e_be;
   logic [4:0]  e_wb_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      else n_pass++;
   endtask

   function automatic int nbytes(input logic [1:0] size);
      return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [3:0] model_be(input int off, input int n);
      logic [3:0] be = 4'b0000;
      for (int k = 0; k < n; k++) be[off+k] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [31:0] w, input int n);
      logic [31:0] r = 32'h0;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] rdata, input int off,
                                              input int n, input bit sext);
      longint v = 0;
      for (int k = n - 1; k >= 0; k--) v = v * 256 + longint'((rdata >> (8 * (off + k))) & 32'hFF);
      if (sext && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      return 32'(v);
   endfunction

   task automatic model_reset();
      m_phase = 0; t_load = 0; t_sext = 0; t_off = 0; t_n = 1; t_rd = '0;
      e_ready = 1; e_mis = 0; e_req = 0; e_we = 0; e_wb_en = 0;
      e_addr = '0; e_wdata = '0; e_wb_data = '0; e_be = '0; e_wb_addr = '0;
   endtask

   // advance the model across one clock edge using the currently driven inputs
   task automatic model_edge();
      bit nmis = 0;
      bit nwb  = 0;
      if (m_phase == 0) begin
         if (lsu_req_i) begin
            t_off  = int'(lsu_addr_i[1:0]);
            t_n    = nbytes(lsu_size_i);
            t_load = !lsu_we_i;
            t_sext = lsu_sign_ext_i;
            t_rd   = lsu_rd_addr_i;
            if (t_off % t_n != 0) nmis = 1;
            else begin
               m_phase = 1;
               e_addr  = lsu_addr_i & ~32'h3;
               e_we    = lsu_we_i;
               e_be    = model_be(t_off, t_n);
               e_wdata = model_wdata(lsu_wdata_i, t_n);
            end
         end
      end else if (m_phase == 1) begin
         if (data_gnt_i) m_phase = 2;
      end else if (data_rvalid_i) begin
         m_phase = 0;
         if (t_load && t_rd != 0) begin
            nwb       = 1;
            e_wb_addr = t_rd;
            e_wb_data = model_load(data_rdata_i, t_off, t_n, t_sext);
         end
      end
      e_mis   = nmis;
      e_wb_en = nwb;
      e_req   = (m_phase == 1);
      e_ready = (m_phase == 0);
   endtask

   task automatic compare_all(input bit full);
      chk("ready", lsu_ready_o, e_ready);
      chk("misaligned", misaligned_o, e_mis);
      chk("data_req", data_req_o, e_req);
      chk("wb_en", wb_en_o, e_wb_en);
      if (full || e_req) begin
         chk("data_addr", data_addr_o, e_addr);
         chk("data_we", data_we_o, e_we);
         chk("data_be", data_be_o, e_be);
         chk("data_wdata", data_wdata_o, e_wdata);
      end
      if (full || e_wb_en) begin
         chk("wb_addr", wb_addr_o, e_wb_addr);
         chk("wb_data", wb_data_o, e_wb_data);
      end
   endtask

   task automatic cycle(input bit req, input bit we, input logic [1:0] size, input bit sext,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input bit gnt, input bit rvalid, input logic [31:0] rdata);
      lsu_req_i = req; lsu_we_i = we; lsu_size_i = size; lsu_sign_ext_i = sext;
      lsu_addr_i = addr; lsu_wdata_i = wdata; lsu_rd_addr_i = rd;
      data_gnt_i = gnt; data_rvalid_i = rvalid; data_rdata_i = rdata;
      model_edge();
      @(posedge clk);
      #1;
      compare_all(0);
   endtask

   task automatic idle(input bit gnt, input bit rvalid, input logic [31:0] rdata);
      cycle(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, gnt, rvalid, rdata);
   endtask

   task automatic apply_reset();
      lsu_req_i = 0; data_gnt_i = 0; data_rvalid_i = 0;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all(1);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      lsu_req_i = 0; lsu_we_i = 0; lsu_size_i = 0; lsu_sign_ext_i = 0;
      lsu_addr_i = 0; lsu_wdata_i = 0; lsu_rd_addr_i = 0;
      data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0;
      rst_n = 1'b1;
      #2;
      apply_reset();
      idle(0, 0, 0);

      // signed byte load at offset 3, immediate grant and response
      cycle(1, 0, 2'b00, 1, 32'h0000_1003, 32'h0, 5'd5, 0, 0, 0);
      chk("lb_be_lit", data_be_o, 32'h8);
      chk("lb_addr_lit", data_addr_o, 32'h0000_1000);
      chk("lb_ready_lit", lsu_ready_o, 0);
      idle(1, 0, 0);
      idle(0, 1, 32'h80FF_FFFF);
      chk("lb_wben_lit", wb_en_o, 1);
      chk("lb_wbdata_lit", wb_data_o, 32'hFFFF_FF80);
      chk("lb_wbaddr_lit", wb_addr_o, 5);
      chk("lb_ready_back_lit", lsu_ready_o, 1);
      idle(0, 0, 0);

      // half store with a grant three cycles late
      cycle(1, 1, 2'b01, 0, 32'h0000_2002, 32'h1234_ABCD, 5'd7, 0, 0, 0);
      chk("sh_be_lit", data_be_o, 32'hC);
      chk("sh_wdata_lit", data_wdata_o, 32'hABCD_ABCD);
      chk("sh_we_lit", data_we_o, 1);
      for (int i = 0; i < 3; i++) begin
         idle(0, 0, 0);
         chk("sh_req_held_lit", data_req_o, 1);
      end
      idle(1, 0, 0);
      chk("sh_req_drop_lit", data_req_o, 0);
      idle(0, 1, 32'hFFFF_FFFF);
      chk("sh_no_wb_lit", wb_en_o, 0);

      // misaligned word load
      cycle(1, 0, 2'b10, 0, 32'h0000_3001, 32'h0, 5'd9, 0, 0, 0);
      chk("mis_pulse_lit", misaligned_o, 1);
      chk("mis_noreq_lit", data_req_o, 0);
      chk("mis_ready_lit", lsu_ready_o, 1);
      idle(1, 0, 0);
      chk("mis_end_lit", misaligned_o, 0);

      // unsigned half load to x0: bus traffic but no write-back
      cycle(1, 0, 2'b01, 0, 32'h0000_4002, 32'h0, 5'd0, 0, 0, 0);
      chk("x0_req_lit", data_req_o, 1);
      idle(1, 0, 0);
      idle(0, 1, 32'hBEEF_0000);
      chk("x0_no_wb_lit", wb_en_o, 0);

      // back-to-back loads, second accepted in the first one's write-back cycle
      cycle(1, 0, 2'b10, 0, 32'h0000_5000, 32'h0, 5'd3, 0, 0, 0);
      idle(1, 0, 0);
      idle(0, 1, 32'hCAFE_F00D);
      chk("b2b_wb1_lit", wb_data_o, 32'hCAFE_F00D);
      cycle(1, 0, 2'b00, 0, 32'h0000_6001, 32'h0, 5'd4, 1, 0, 0);
      chk("b2b_req2_lit", data_req_o, 1);
      idle(1, 0, 0);
      idle(0, 1, 32'h0000_A500);
      chk("b2b_wb2_lit", wb_data_o, 32'h0000_00A5);
      chk("b2b_wbaddr2_lit", wb_addr_o, 4);

      // reset while awaiting the response; late response must be ignored
      cycle(1, 0, 2'b10, 0, 32'h0000_7000, 32'h0, 5'd6, 0, 0, 0);
      idle(1, 0, 0);
      apply_reset();
      idle(0, 1, 32'h1111_2222);
      chk("rst_no_wb_lit", wb_en_o, 0);
      chk("rst_ready_lit", lsu_ready_o, 1);

      // randomized traffic with a well-behaved bus responder
      for (int c = 0; c < 3000; c++) begin
         bit          req, gnt, rv;
         logic [31:0] addr;
         if (c % 700 == 699) apply_reset();
         req  = ($urandom_range(0, 2) == 0);
         addr = $urandom;
         gnt  = ($urandom_range(0, 1) == 1);
         rv   = (m_phase == 2) ? ($urandom_range(0, 2) != 0)
              : (m_phase == 0) ? ($urandom_range(0, 9) == 0) : 1'b0;
         cycle(req, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), addr, $urandom, 5'($urandom_range(0, 31)),
               gnt, rv, $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
